mips_reg_dump: RTL and testbench
================================

// Module: mips_reg_dump
// PURPOSE
//   Post-halt register-file readout engine for the pipelined MIPS32 core.
//   When the core halts (HLT retired), it walks REG[0..NUM_REGS-1] through a
//   read port and streams each (index, value) over a valid/ready interface.
//   It also accumulates a sum checksum, so the host/bench can read results
//   without hierarchical peeking. It is the read-out end of the load path
//   that preloads Mem and REG before PC release.
// PARAMETERS
//   NUM_REGS  32  number of registers dumped, indices 0..NUM_REGS-1
//   DATA_W    32  register width
//   IDX_W     5   index width, must satisfy 2**IDX_W >= NUM_REGS
// PORTS
//   clk1        in   1       single clock (core phase-1 clock)
//   rst_n       in   1       asynchronous active-low reset
//   halted      in   1       core HALTED flag
//   rf_rd_addr  out  IDX_W   register-file read address
//   rf_rd_data  in   DATA_W  combinational read data for rf_rd_addr
//   dump_valid  out  1       stream beat valid
//   dump_ready  in   1       sink accepts beat
//   dump_idx    out  IDX_W   register index of current beat
//   dump_data   out  DATA_W  register value of current beat
//   dump_last   out  1       high with the beat for index NUM_REGS-1
//   busy        out  1       dump in progress (FETCH or SEND)
//   done        out  1       full dump completed, held in DONE
//   csum        out  DATA_W  sum of all accepted dump_data, mod 2**DATA_W
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; all outputs 0; idx=0; csum=0;
//     halted_q=0. If halted=1 at reset release, that counts as a rising edge.
//   Trigger: rising edge of halted (halted & ~halted_q), sampled on clk1.
//   FSM:
//     IDLE  : on trigger -> FETCH; idx<=0; csum<=0; done stays 0.
//     FETCH : rf_rd_addr=idx; capture rf_rd_data into data_q at the edge;
//             -> SEND.
//     SEND  : dump_valid=1; dump_idx=idx; dump_data=data_q;
//             dump_last=(idx==NUM_REGS-1).
//             On valid&ready: csum<=csum+data_q (wraps mod 2**DATA_W).
//               If last -> DONE. Else idx<=idx+1 and -> FETCH.
//             If ready is low, hold idx, data and last stable.
//     DONE  : done=1; csum frozen; -> IDLE when halted falls.
//   Abort: halted=0 in FETCH or SEND -> IDLE at the next edge.
//     valid drops without a handshake; the partial csum stays readable.
//     done stays 0.
//   A new trigger always restarts at idx 0 with csum cleared.
//   busy=1 exactly in FETCH and SEND.
//   rf_rd_addr holds idx in every state; it is 0 after reset.
//   Throughput: 1 beat per 2 cycles with ready tied high.
//     Trigger to first valid = 2 cycles (IDLE->FETCH->SEND).
//   Outputs are registered or decoded from state only; no comb path from
//     dump_ready to dump_valid.
// TESTING
//   1 Baseline: REG[k]=k, ready=1, halted 0->1
//       -> 32 beats, idx/data 0..31, last only on idx 31;
//          done=1; csum=0x000001F0.
//   2 Backpressure: ready=0 for 5 cycles during beat idx 3
//       -> valid, idx=3, data=3 held stable; stream resumes;
//          final csum=0x1F0.
//   3 Wrap: REG[k]=32'hFFFFFFFF for all k
//       -> every beat data=FFFFFFFF; csum=32'hFFFFFFE0.
//   4 Abort: halted falls after beat 10 accepted
//       -> next cycle IDLE, valid=0, done=0;
//          re-raise halted -> restart at idx 0, final csum=0x1F0.
//   5 Reset mid-dump: rst_n=0 during SEND of idx 7
//       -> all outputs 0 immediately (async);
//          halted held 1 through release -> new dump from idx 0.
//   6 Re-arm: in DONE, halted 1->0->1
//       -> back to IDLE, then a second full identical dump.

Source files
------------

// File: rtl/mips_reg_dump_if.sv
// Valid/ready stream carrying one (index, value) register beat per handshake.
interface mips_reg_dump_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              dump_valid;
    logic              dump_ready;
    logic [IDX_W-1:0]  dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/mips_reg_dump.sv
// Post-halt register-file readout: walks REG[0..NUM_REGS-1] on a rising halted
// edge, streams each (index, value) beat and keeps a running sum checksum.
module mips_reg_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              halted,
    output logic [IDX_W-1:0]  rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    mips_reg_dump_if.master   dump,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] csum
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data_q;
    logic              halted_q;
    logic              trigger;
    logic              is_last;

    // halted_q resets to 0, so a core already halted at reset release triggers a dump
    assign trigger = halted & ~halted_q;
    assign is_last = (idx == LAST_IDX);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            data_q   <= '0;
            csum     <= '0;
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= FETCH;
                        idx   <= '0;
                        csum  <= '0;
                    end
                end
                FETCH: begin
                    if (!halted) begin
                        state <= IDLE;
                    end else begin
                        data_q <= rf_rd_data;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    // Abort wins over a same-cycle handshake so the beat is never counted
                    if (!halted) begin
                        state <= IDLE;
                    end else if (dump.dump_ready) begin
                        csum <= csum + data_q;
                        if (is_last) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (!halted) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rf_rd_addr      = idx;
    assign dump.dump_valid = (state == SEND);
    assign dump.dump_idx   = idx;
    assign dump.dump_data  = (state == SEND) ? data_q : '0;
    assign dump.dump_last  = (state == SEND) && is_last;
    assign busy            = (state == FETCH) || (state == SEND);
    assign done            = (state == DONE);

endmodule

// File: tb/tb_mips_reg_dump.sv
// Directed bench for mips_reg_dump: cycle table plus full-dump, stall, wrap,
// abort, async-reset and re-arm sequences against a local register model.
module tb_mips_reg_dump;

    logic        clk1;
    logic        rst_n;
    logic        halted;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        busy;
    logic        done;
    logic [31:0] csum;
    logic [31:0] regs [32];

    int total;
    int bad;

    mips_reg_dump_if #(.DATA_W(32), .IDX_W(5)) dif ();

    mips_reg_dump #(.NUM_REGS(32), .DATA_W(32), .IDX_W(5)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .halted     (halted),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .dump       (dif),
        .busy       (busy),
        .done       (done),
        .csum       (csum)
    );

    assign rf_rd_data = regs[rf_rd_addr];

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        logic        halted;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
        logic [31:0] exp_csum;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic r);
        halted         = h;
        dif.dump_ready = r;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, dif.dump_valid}, 32'd0);
        checkOutput({tag, "_idx"},   {27'd0, dif.dump_idx},   32'd0);
        checkOutput({tag, "_data"},  dif.dump_data,           32'd0);
        checkOutput({tag, "_last"},  {31'd0, dif.dump_last},  32'd0);
        checkOutput({tag, "_busy"},  {31'd0, busy},           32'd0);
        checkOutput({tag, "_done"},  {31'd0, done},           32'd0);
        checkOutput({tag, "_csum"},  csum,                    32'd0);
        checkOutput({tag, "_addr"},  {27'd0, rf_rd_addr},     32'd0);
    endtask

    // Collects a whole dump beat by beat; optionally holds ready low on one beat
    task automatic collectDump(input string tag, input int stallIdx, input int stallCycles,
                               input logic [31:0] expCsum);
        int  k       = 0;
        int  cyc     = 0;
        bit  stalled = 0;
        while (k < 32 && cyc < 400) begin
            @(negedge clk1);
            cyc++;
            if (dif.dump_valid) begin
                checkOutput($sformatf("%s_idx%0d", tag, k),  {27'd0, dif.dump_idx}, k);
                checkOutput($sformatf("%s_data%0d", tag, k), dif.dump_data, regs[k]);
                checkOutput($sformatf("%s_last%0d", tag, k), {31'd0, dif.dump_last}, (k == 31) ? 32'd1 : 32'd0);
                if (k == stallIdx && !stalled) begin
                    stalled        = 1;
                    dif.dump_ready = 1'b0;
                    repeat (stallCycles) begin
                        @(negedge clk1);
                        checkOutput({tag, "_stall_valid"}, {31'd0, dif.dump_valid}, 32'd1);
                        checkOutput({tag, "_stall_idx"},   {27'd0, dif.dump_idx},   k);
                        checkOutput({tag, "_stall_data"},  dif.dump_data,           regs[k]);
                    end
                    dif.dump_ready = 1'b1;
                end
                k++;
            end
        end
        if (k < 32) checkOutput({tag, "_timeout_beats"}, k, 32);
        @(negedge clk1);
        checkOutput({tag, "_done"},  {31'd0, done},          32'd1);
        checkOutput({tag, "_busy"},  {31'd0, busy},          32'd0);
        checkOutput({tag, "_valid"}, {31'd0, dif.dump_valid}, 32'd0);
        checkOutput({tag, "_csum"},  csum,                   expCsum);
    endtask

    task automatic waitBeat(input string tag, input int k);
        int cyc = 0;
        @(negedge clk1);
        while (!(dif.dump_valid && dif.dump_idx == 5'(k)) && cyc < 200) begin
            @(negedge clk1);
            cyc++;
        end
        if (cyc >= 200) checkOutput({tag, "_timeout"}, cyc, 0);
    endtask

    task automatic rearm();
        applyStimulus(1'b0, 1'b1);
        @(negedge clk1);
        applyStimulus(1'b1, 1'b1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);

        // halted, ready, valid, idx, data, busy, done, csum
        vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 32'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd1, 32'd1, 1'b1, 1'b0, 32'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd1, 32'd1, 1'b1, 1'b0, 32'd0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 1'b1, 1'b0, 32'd1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 5'd2, 32'd2, 1'b1, 1'b0, 32'd1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 5'd2, 32'd0, 1'b0, 1'b0, 32'd1};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 5'd2, 32'd0, 1'b0, 1'b0, 32'd1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(negedge clk1);
        checkAllZero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].halted, vecs[i].ready);
            @(negedge clk1);
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, dif.dump_valid}, {31'd0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_idx", i),   {27'd0, dif.dump_idx},   {27'd0, vecs[i].exp_idx});
            checkOutput($sformatf("vec%0d_addr", i),  {27'd0, rf_rd_addr},     {27'd0, vecs[i].exp_idx});
            checkOutput($sformatf("vec%0d_busy", i),  {31'd0, busy},           {31'd0, vecs[i].exp_busy});
            checkOutput($sformatf("vec%0d_done", i),  {31'd0, done},           {31'd0, vecs[i].exp_done});
            checkOutput($sformatf("vec%0d_csum", i),  csum,                    vecs[i].exp_csum);
            if (vecs[i].exp_valid)
                checkOutput($sformatf("vec%0d_data", i), dif.dump_data, vecs[i].exp_data);
        end

        // Baseline full dump, then done must hold while halted stays high
        applyStimulus(1'b1, 1'b1);
        collectDump("base", -1, 0, 32'h0000_01F0);
        repeat (3) @(negedge clk1);
        checkOutput("base_done_hold", {31'd0, done}, 32'd1);
        checkOutput("base_csum_hold", csum, 32'h0000_01F0);

        // Re-arm from DONE: halted falls returns to IDLE, then a second dump
        applyStimulus(1'b0, 1'b1);
        @(negedge clk1);
        checkOutput("rearm_idle_done", {31'd0, done}, 32'd0);
        checkOutput("rearm_idle_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 1'b1);
        collectDump("rearm", -1, 0, 32'h0000_01F0);

        rearm();
        collectDump("bp", 3, 5, 32'h0000_01F0);

        for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
        rearm();
        collectDump("wrap", -1, 0, 32'hFFFF_FFE0);
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);

        // Abort right after beat 10 is accepted; partial sum 0..10 stays visible
        rearm();
        waitBeat("abort", 10);
        @(negedge clk1);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk1);
        checkOutput("abort_valid", {31'd0, dif.dump_valid}, 32'd0);
        checkOutput("abort_busy",  {31'd0, busy},           32'd0);
        checkOutput("abort_done",  {31'd0, done},           32'd0);
        checkOutput("abort_csum",  csum,                    32'd55);
        applyStimulus(1'b1, 1'b1);
        collectDump("restart", -1, 0, 32'h0000_01F0);

        // Async reset in the middle of beat 7, halted held high through release
        rearm();
        waitBeat("rst", 7);
        #2 rst_n = 1'b0;
        #1 checkAllZero("rst_async");
        @(negedge clk1);
        rst_n = 1'b1;
        collectDump("post_rst", -1, 0, 32'h0000_01F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
